mvm_frame_ctrl: RTL and testbench

- Sequencer between the UART byte streams and the matrix-vector multiply core.
- Assembles N_WORDS_KX received bytes into the packed {K, X} operand bus.
- Issues a one-cycle start to the core and captures the packed Y result on done.
- Streams N_WORDS_Y result bytes to the UART transmitter with a valid/ready handshake, then re-arms for the next frame.

---
 rtl/mvm_frame_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mvm_frame_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mvm_frame_ctrl.sv
// Frame sequencer between the UART byte streams and the MVM core.
// Optional inter-byte timeout: define MVM_FRAME_CTRL_TIMEOUT_EN.
module mvm_frame_ctrl #(
    parameter int R              = 4,
    parameter int C              = 4,
    parameter int W_X            = 4,
    parameter int W_K            = 2,
    parameter int W_Y_OUT        = 10,
    parameter int BITS_PER_WORD  = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             s_valid,
    input  logic [BITS_PER_WORD-1:0]         s_data,
    output logic                             s_ready,
    output logic [R*C*W_K+C*W_X-1:0]         mvm_kx,
    output logic                             mvm_start,
    input  logic                             mvm_done,
    input  logic [R*W_Y_OUT-1:0]             mvm_y,
    output logic                             m_valid,
    output logic [BITS_PER_WORD-1:0]         m_data,
    input  logic                             m_ready,
    output logic                             busy,
    output logic                             overrun
);

    localparam int BW         = BITS_PER_WORD;
    localparam int W_BUS_KX   = R*C*W_K + C*W_X;
    localparam int W_BUS_Y    = R*W_Y_OUT;
    localparam int N_WORDS_KX = W_BUS_KX / BW;
    localparam int N_WORDS_Y  = W_BUS_Y / BW;
    localparam int CW = (N_WORDS_KX > 1) ? $clog2(N_WORDS_KX) : 1;
    localparam int IW = (N_WORDS_Y > 1) ? $clog2(N_WORDS_Y) : 1;

    if (W_BUS_KX % BITS_PER_WORD != 0) begin : g_kx_chk
        $error("W_BUS_KX must be a multiple of BITS_PER_WORD");
    end
    if (W_BUS_Y % BITS_PER_WORD != 0) begin : g_y_chk
        $error("W_BUS_Y must be a multiple of BITS_PER_WORD");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_tmo_chk
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        S_RECV,
        S_START,
        S_WAIT,
        S_SEND
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [W_BUS_KX-1:0] r_kx;
    logic [W_BUS_Y-1:0]  r_y;
    logic                r_overrun;

    logic                w_acc;
    logic                w_last_kx;
    logic                w_xfer;
    logic                w_last_y;
    logic                w_tmo;
    logic [BW-1:0]       w_mdata;

    assign w_acc     = s_valid && (r_state == S_RECV);
    assign w_last_kx = (r_cnt == CW'(N_WORDS_KX - 1));
    assign w_xfer    = (r_state == S_SEND) && m_ready;
    assign w_last_y  = (r_idx == IW'(N_WORDS_Y - 1));

`ifdef MVM_FRAME_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] r_tmo;

    // Idle counter only runs while a partial frame is pending.
    assign w_tmo = (r_state == S_RECV) && (r_cnt != '0) && !s_valid
                && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tmo <= '0;
        end else if ((r_state != S_RECV) || (r_cnt == '0) || w_acc || w_tmo) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TW'(1);
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_RECV;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        s_ready   = 1'b0;
        mvm_start = 1'b0;
        m_valid   = 1'b0;
        unique case (r_state)
            S_RECV: begin
                s_ready = 1'b1;
                if (w_acc && w_last_kx) w_next = S_START;
            end
            S_START: begin
                mvm_start = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (mvm_done) w_next = S_SEND;
            end
            S_SEND: begin
                m_valid = 1'b1;
                if (w_xfer && w_last_y) w_next = S_RECV;
            end
            default: w_next = S_RECV;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (w_acc) begin
            r_cnt <= w_last_kx ? '0 : r_cnt + CW'(1);
        end else if (w_tmo) begin
            r_cnt <= '0;
        end
    end

    // Lanes are written in place so the bus holds between frames.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_kx <= '0;
        end else begin
            for (int i = 0; i < N_WORDS_KX; i++) begin
                if (w_acc && (r_cnt == CW'(i))) begin
                    r_kx[i*BW +: BW] <= s_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_y <= '0;
        end else if ((r_state == S_WAIT) && mvm_done) begin
            r_y <= mvm_y;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx <= '0;
        end else if (w_xfer) begin
            r_idx <= w_last_y ? '0 : r_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overrun <= 1'b0;
        end else if (s_valid && (r_state != S_RECV)) begin
            r_overrun <= 1'b1;
        end
    end

    always_comb begin
        w_mdata = '0;
        for (int i = 0; i < N_WORDS_Y; i++) begin
            if (r_idx == IW'(i)) w_mdata = r_y[i*BW +: BW];
        end
    end

    assign m_data  = w_mdata;
    assign mvm_kx  = r_kx;
    assign overrun = r_overrun;
    assign busy    = (r_state != S_RECV) || (r_cnt != '0);

endmodule

// File: tb/tb_mvm_frame_ctrl.sv
// Scoreboard bench for mvm_frame_ctrl (default 6 KX bytes, 5 Y bytes).
module tb_mvm_frame_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic [47:0] mvm_kx;
    logic        mvm_start;
    logic        mvm_done = 1'b0;
    logic [39:0] mvm_y = '0;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready = 1'b0;
    logic        busy;
    logic        overrun;

    int n_chk = 0;
    int n_err = 0;
    int n_start = 0;
    logic [7:0] q[$];

    mvm_frame_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mvm_kx(mvm_kx), .mvm_start(mvm_start),
        .mvm_done(mvm_done), .mvm_y(mvm_y),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rstn && mvm_start) n_start++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        step();
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] kx);
        int s0;
        s0 = n_start;
        for (int i = 0; i < 6; i++) begin
            check("s_ready_recv", s_ready, 1);
            send_byte(kx[i*8 +: 8]);
        end
        check("start_pulse", mvm_start, 1);
        check("kx", mvm_kx, kx);
        check("s_ready_start", s_ready, 0);
        step();
        check("start_once", mvm_start, 0);
        check("s_ready_wait", s_ready, 0);
        check("kx_hold", mvm_kx, kx);
        check("n_start", n_start - s0, 1);
    endtask

    task automatic result(input logic [39:0] y, input int mode);
        int cyc;
        int xf;
        logic [7:0] e;
        mvm_done = 1'b1;
        mvm_y    = y;
        for (int i = 0; i < 5; i++) q.push_back(y[i*8 +: 8]);
        step();
        mvm_done = 1'b0;
        mvm_y    = '0;
        cyc = 0;
        xf  = 0;
        while (q.size() > 0 && cyc < 100) begin
            m_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            check("m_valid", m_valid, 1);
            if (m_ready) begin
                e = q.pop_front();
                check("m_data", m_data, e);
                xf++;
            end else begin
                check("m_hold", m_data, q[0]);
            end
            step();
            cyc++;
        end
        m_ready = 1'b0;
        check("drain_left", q.size(), 0);
        q.delete();
        check("xfers", xf, 5);
        check("drain_cycles", cyc, (mode == 0) ? 5 : 13);
        check("m_valid_end", m_valid, 0);
        check("s_ready_end", s_ready, 1);
        check("busy_end", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        int s0;
        repeat (3) step();
        rstn = 1'b1;
        step();
        check("rst_s_ready", s_ready, 1);
        check("rst_start", mvm_start, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_kx", mvm_kx, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", busy, 0);

        send_frame(48'h665544332211);
        result(40'hAABBCCDDEE, 0);

        // Frame with a done raised during START, which must be ignored.
        for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i));
        send_byte(8'h2F);
        check("start_b", mvm_start, 1);
        mvm_done = 1'b1;
        mvm_y    = 40'hDEADDEADDE;
        step();
        mvm_done = 1'b0;
        step();
        check("done_in_start", m_valid, 0);
        check("kx_b", mvm_kx, 48'h2F2423222120);
        result(40'h0102030405, 1);

        send_frame(48'hC6C5C4C3C2C1);
        check("ovr_pre", overrun, 0);
        send_byte(8'hEE);
        check("ovr_set", overrun, 1);
        check("kx_ovr", mvm_kx, 48'hC6C5C4C3C2C1);
        result(40'h123456789A, 0);
        send_frame(48'h0F0E0D0C0B0A);
        result(40'hF0E1D2C3B4, 1);
        check("ovr_sticky", overrun, 1);

        send_byte(8'h91);
        send_byte(8'h92);
        send_byte(8'h93);
        check("busy_partial", busy, 1);
        rstn = 1'b0;
        step();
        check("rst_mid_busy", busy, 0);
        check("rst_mid_kx", mvm_kx, 0);
        check("rst_mid_ovr", overrun, 0);
        rstn = 1'b1;
        step();
        s0 = n_start;
        send_frame(48'h363534333231);
        check("rst_mid_starts", n_start - s0, 1);
        result(40'h5555AAAA55, 0);

`ifdef MVM_FRAME_CTRL_TIMEOUT_EN
        s0 = n_start;
        send_byte(8'hA1);
        send_byte(8'hA2);
        repeat (20) step();
        check("tmo_busy", busy, 0);
        check("tmo_no_start", n_start - s0, 0);
        check("tmo_lanes_kept", mvm_kx[15:0], 16'hA2A1);
        send_frame(48'h060504030201);
        check("tmo_starts", n_start - s0, 1);
        result(40'h0011223344, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
